// File: rtl/obs_pkg.sv
// Shared types and sizing helpers for the serial carry-less multiplier.
// N_DIG and the counter width are computed here so the top and the bench agree.
package obs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int n_dig(input int w, input int d);
    return (w + d - 1) / d;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/obs_clmul_digit.sv
// Combinational carry-less product of a W-bit operand and one D-bit digit of b.
// Full-width result (W+D-1 bits), no truncation; pure XOR/AND tree.
module obs_clmul_digit #(
  parameter int W = 131,
  parameter int D = 32
) (
  input  logic [W-1:0]   a,
  input  logic [D-1:0]   bdig,
  output logic [W+D-2:0] p
);

  logic [W+D-2:0] ax;

  assign ax = (W+D-1)'(a);

  always_comb begin
    p = '0;
    for (int j = 0; j < D; j++) begin
      if (bdig[j]) p = p ^ (ax << j);
    end
  end

endmodule

// File: rtl/obs_serial_mul.sv
// Digit-serial GF(2) polynomial multiplier with optional XOR accumulation into y.
// Fixed latency of N_DIG cycles from acceptance; result held in DONE until out_ready.
module obs_serial_mul
  import obs_pkg::*;
#(
  parameter int W = 131,
  parameter int D = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           acc_en,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-2:0] y,
  output logic           busy
);

  localparam int N_DIG = n_dig(W, D);
  localparam int CW    = cnt_width(N_DIG);
  localparam int BW    = N_DIG * D;
  localparam int YW    = 2 * W - 1;
  localparam int PW    = W + D - 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [BW-1:0]   b_q, b_d;
  logic [YW-1:0]   acc_q, acc_d;
  logic [YW-1:0]   y_q, y_d;
  logic [PW-1:0]   p;
  logic [YW-1:0]   p_ext, p_sh;

  // b is zero-padded to N_DIG*D and shifted down one digit per cycle,
  // so the digit under process always sits in the low D bits.
  obs_clmul_digit #(.W(W), .D(D)) u_digit (
    .a    (a_q),
    .bdig (b_q[D-1:0]),
    .p    (p)
  );

  always_comb begin
    p_ext = '0;
    p_ext[PW-1:0] = p;
    p_sh = p_ext << (int'(cnt_q) * D);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d           = a;
          b_d           = '0;
          b_d[W-1:0]    = b;
          cnt_d         = '0;
          acc_d         = acc_en ? y_q : '0;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_q ^ p_sh;
        b_d   = b_q >> D;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N_DIG - 1)) begin
          y_d     = acc_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign y         = y_q;

endmodule

// File: tb/tb_obs_serial_mul.sv
// Directed and randomised checks of obs_serial_mul over several W/D configurations.
// Expected products come from a bitwise carry-less reference and a per-instance y model.
module tb_obs_serial_mul;

  localparam int NC = 7;
  localparam int WM = 131;
  localparam int YM = 261;

  function automatic int cfg_w(input int g);
    case (g)
      1, 2, 3: return 8;
      default: return 131;
    endcase
  endfunction

  function automatic int cfg_d(input int g);
    case (g)
      0:       return 32;
      1, 4:    return 1;
      2, 5:    return 7;
      3:       return 8;
      default: return 131;
    endcase
  endfunction

  function automatic int cfg_n(input int g);
    return (cfg_w(g) + cfg_d(g) - 1) / cfg_d(g);
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NC-1:0]          in_valid_s, in_ready_s, acc_en_s, out_valid_s, out_ready_s, busy_s;
  logic [NC-1:0][WM-1:0]  a_s, b_s;
  logic [NC-1:0][YM-1:0]  y_s;

  for (genvar g = 0; g < NC; g++) begin : gi
    localparam int W = cfg_w(g);
    localparam int D = cfg_d(g);
    logic [2*W-2:0] yw;
    obs_serial_mul #(.W(W), .D(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_s[g]),
      .in_ready  (in_ready_s[g]),
      .a         (a_s[g][W-1:0]),
      .b         (b_s[g][W-1:0]),
      .acc_en    (acc_en_s[g]),
      .out_valid (out_valid_s[g]),
      .out_ready (out_ready_s[g]),
      .y         (yw),
      .busy      (busy_s[g])
    );
    assign y_s[g] = YM'(yw);
  end

  int total = 0;
  int bad   = 0;
  logic [YM-1:0] sb_q[$];
  logic [YM-1:0] ymodel[NC];

  task automatic check(input string tag, input logic [YM-1:0] obs, input logic [YM-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WM-1:0] msk(input logic [WM-1:0] v, input int w);
    logic [WM-1:0] m;
    m = '0;
    for (int i = 0; i < w; i++) m[i] = 1'b1;
    return v & m;
  endfunction

  function automatic logic [YM-1:0] clmul(input logic [WM-1:0] x, input logic [WM-1:0] z, input int w);
    logic [YM-1:0] r;
    r = '0;
    for (int j = 0; j < w; j++) begin
      if (z[j]) r = r ^ (YM'(x) << j);
    end
    return r;
  endfunction

  function automatic logic [WM-1:0] rnd();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[WM-1:0];
  endfunction

  // Present one operand pair on the cycle after the call; returns just past the acceptance edge.
  task automatic start(input int g, input logic [WM-1:0] av, input logic [WM-1:0] bv, input logic acc);
    logic [YM-1:0] prod, exp;
    check("in_ready_before_start", YM'(in_ready_s[g]), YM'(1'b1));
    prod = clmul(msk(av, cfg_w(g)), msk(bv, cfg_w(g)), cfg_w(g));
    exp  = acc ? (ymodel[g] ^ prod) : prod;
    ymodel[g] = exp;
    sb_q.push_back(exp);
    a_s[g] = msk(av, cfg_w(g));
    b_s[g] = msk(bv, cfg_w(g));
    acc_en_s[g] = acc;
    in_valid_s[g] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_s[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input string tag);
    int lat;
    logic [YM-1:0] exp;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid_s[g] && lat < 2000);
    check({tag, "_latency"}, YM'(lat), YM'(cfg_n(g)));
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    check({tag, "_y"}, y_s[g], exp);
  endtask

  task automatic handshake(input int g, input string tag);
    out_ready_s[g] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_s[g] = 1'b0;
    check({tag, "_ovld_fall"}, YM'(out_valid_s[g]), YM'(1'b0));
    check({tag, "_irdy_back"}, YM'(in_ready_s[g]), YM'(1'b1));
    check({tag, "_y_retained"}, y_s[g], ymodel[g]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [YM-1:0] even;
    logic [YM-1:0] y_hold;
    logic          ok;
    int            nops;

    in_valid_s = '0; acc_en_s = '0; out_ready_s = '0; a_s = '0; b_s = '0;
    for (int g = 0; g < NC; g++) ymodel[g] = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_in_ready", YM'(in_ready_s[0]), YM'(1'b1));
    check("reset_out_valid", YM'(out_valid_s[0]), YM'(1'b0));
    check("reset_busy", YM'(busy_s[0]), YM'(1'b0));
    check("reset_y", y_s[0], '0);
    rst = 1'b0;

    // all-ones squared: only even coefficients survive
    start(0, '1, '1, 1'b0);
    check("busy_after_accept", YM'(busy_s[0]), YM'(1'b1));
    check("in_ready_low_busy", YM'(in_ready_s[0]), YM'(1'b0));
    wait_done(0, "ones");
    even = '0;
    for (int i = 0; i <= 260; i += 2) even[i] = 1'b1;
    check("ones_even_bits", y_s[0], even);
    handshake(0, "ones");

    start(0, WM'(1), WM'(1), 1'b0);
    wait_done(0, "one");
    check("one_value", y_s[0], YM'(1));
    handshake(0, "one");
    start(0, WM'(1), WM'(1), 1'b1);
    wait_done(0, "one_acc");
    check("one_acc_value", y_s[0], YM'(0));
    handshake(0, "one_acc");

    start(0, WM'(1) << 130, WM'(1) << 130, 1'b0);
    wait_done(0, "top");
    check("top_value", y_s[0], YM'(1) << 260);
    handshake(0, "top");
    start(0, WM'(33), WM'(10), 1'b0);
    wait_done(0, "small");
    check("small_value", y_s[0], YM'(9'h14A));
    handshake(0, "small");

    // hold DONE with out_ready low while in_valid and fresh operands are offered
    start(0, rnd(), rnd(), 1'b0);
    wait_done(0, "hold");
    y_hold = y_s[0];
    in_valid_s[0] = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_s[0] = rnd();
      b_s[0] = rnd();
      @(posedge clk);
      #1;
      if (y_s[0] !== y_hold || out_valid_s[0] !== 1'b1 || in_ready_s[0] !== 1'b0) ok = 1'b0;
    end
    check("hold_stable", YM'(ok), YM'(1'b1));
    in_valid_s[0] = 1'b0;
    handshake(0, "hold");
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid_s[0] !== 1'b0 || busy_s[0] !== 1'b0) ok = 1'b0;
    end
    check("hold_no_capture", YM'(ok), YM'(1'b1));

    // abort in BUSY cycle 2
    start(0, rnd(), rnd(), 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("abort_busy_before", YM'(busy_s[0]), YM'(1'b1));
    #2;
    rst = 1'b1;
    #1;
    check("abort_y_zero", y_s[0], '0);
    check("abort_in_ready", YM'(in_ready_s[0]), YM'(1'b1));
    check("abort_out_valid", YM'(out_valid_s[0]), YM'(1'b0));
    check("abort_busy", YM'(busy_s[0]), YM'(1'b0));
    void'(sb_q.pop_front());
    for (int g = 0; g < NC; g++) ymodel[g] = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid_s[0] !== 1'b0) ok = 1'b0;
    end
    check("abort_no_pulse", YM'(ok), YM'(1'b1));
    start(0, WM'(3), WM'(3), 1'b0);
    wait_done(0, "post_rst");
    check("post_rst_value", y_s[0], YM'(5));
    handshake(0, "post_rst");
    start(0, WM'(1), WM'(1), 1'b1);
    wait_done(0, "post_rst_acc");
    check("post_rst_acc_value", y_s[0], YM'(4));
    handshake(0, "post_rst_acc");

    // randomised sweep over the other configurations, accumulation included
    for (int g = 1; g < NC; g++) begin
      nops = (g == 4) ? 200 : 1000;
      for (int i = 0; i < nops; i++) begin
        start(g, rnd(), rnd(), 1'($urandom_range(0, 1)));
        wait_done(g, $sformatf("sweep_w%0d_d%0d", cfg_w(g), cfg_d(g)));
        handshake(g, "sweep");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/obs_serial_mul.md
OBS_SERIAL_MUL -- requirements
Module: obs_serial_mul

Interface
REQ-001 Parameter W, default 131: operand width in bits; legal range 2..1024.
REQ-002 Parameter D, default 32: digit width of b processed per cycle; legal range 1..W.
REQ-003 Derived constant N_DIG = ceil(W/D): the number of BUSY cycles; with the defaults, N_DIG = 5.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid  input  1  a, b and acc_en are valid this cycle.
REQ-007 in_ready  output  1  block can accept an operand pair.
REQ-008 a  input  W  operand A, a GF(2) polynomial with bit i as the coefficient of x^i.
REQ-009 b  input  W  operand B, same encoding as a.
REQ-010 acc_en  input  1  XOR the new product into the held y instead of replacing y.
REQ-011 out_valid  output  1  y holds a completed result.
REQ-012 out_ready  input  1  consumer accepts y this cycle.
REQ-013 y  output  2W-1  carry-less product a*b over GF(2), or the accumulated value; no modular reduction.
REQ-014 busy  output  1  high while in state BUSY.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-016 IDLE SHALL drive in_ready=1; an in_valid&&in_ready edge SHALL register a, b and acc_en, clear the digit counter to 0 and move the FSM to BUSY.
REQ-017 At that acceptance edge, the partial accumulator SHALL load 0 when acc_en=0 and the current y when acc_en=1.
REQ-018 Each BUSY cycle k (k=0..N_DIG-1) SHALL XOR into the accumulator the value (a * b[kD+D-1:kD]) << kD, computed carry-less; bits of b at positions >=W SHALL be treated as zero.
REQ-019 After the edge that processes digit N_DIG-1, the FSM SHALL be in DONE, y SHALL equal the accumulator, and out_valid SHALL be 1.
REQ-020 Latency SHALL be exactly N_DIG cycles from the acceptance edge to out_valid rising, independent of operand values.
REQ-021 In DONE, y and out_valid SHALL hold stable until an out_valid&&out_ready edge, which SHALL move the FSM to IDLE.
REQ-022 After that handshake, y SHALL retain its value so that acc_en can accumulate onto it; out_valid SHALL fall.
REQ-023 in_ready SHALL be 0 in BUSY and DONE; in_valid in those states SHALL be ignored, and the a/b inputs SHALL not affect an operation in progress.
REQ-024 The block SHALL not accept a new operand pair in the same cycle as the DONE->IDLE handshake; throughput SHALL be at most one result per N_DIG+2 cycles.
REQ-025 The digit counter SHALL be ceil(log2(N_DIG+1)) bits wide and SHALL never wrap within a single operation.
REQ-026 The top 2W-1..W+D bits of each partial product SHALL be computed at full width with no truncation; product bits above 2W-2 are always zero and SHALL be discarded.

Reset
REQ-027 On assertion of rst, regardless of the current state, the block SHALL immediately force: state=IDLE, in_ready=1, out_valid=0, busy=0, y=0, accumulator=0, digit counter=0, captured operands=0.
REQ-028 Reset during BUSY or DONE SHALL abort the operation, and no out_valid pulse SHALL follow.
REQ-029 Deassertion of rst SHALL take effect at the next clk edge; the first acceptance is possible on that edge.

Structure
REQ-030 A shared package obs_pkg SHALL hold the state enum (IDLE, BUSY, DONE), the N_DIG computation function and the counter-width function.
REQ-031 One combinational sub-module, obs_clmul_digit (parameters W and D; inputs a[W] and bdig[D]; output p[W+D-1]), SHALL compute the per-digit carry-less partial product; the top level instantiates it exactly once.
REQ-032 Shifting by kD and XOR accumulation SHALL reside in obs_serial_mul; no multiplier inference is permitted.

Verification (W=131, D=32 unless stated)
REQ-033 a=b=all ones, acc_en=0 -> y has exactly the even bits 0..260 set and odd bits clear; out_valid rises 5 cycles after acceptance.
REQ-034 a=1, b=1, acc_en=0, then a=1, b=1, acc_en=1 -> first y=1, second y=0.
REQ-035 a=x^130, b=x^130 -> y has only bit 260 set; a=x^5+1, b=x^3+x -> y=x^8+x^6+x^3+x.
REQ-036 Hold out_ready=0 for 10 cycles in DONE -> y and out_valid stay stable and in_ready stays 0; with in_valid=1 throughout, no new capture occurs.
REQ-037 Assert rst at BUSY cycle 2 -> out_valid stays 0, y=0 and in_ready=1 immediately; a following a=3, b=3 yields y=5.
REQ-038 Sweep W in {8, 131} and D in {1, 7, W} with 1000 random operand pairs each -> y matches the bench's bitwise carry-less reference, and latency equals ceil(W/D).
